// File: rtl/prio_enc_pkg.sv
// Shared constants and sizing helper for the N-input priority encoder.
package prio_enc_pkg;
  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

  // Index width that never collapses to zero bits.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/prio_pick_n.sv
// Combinational winner select: highest set bit (fixed) or first set bit at/after ptr (round-robin).
module prio_pick_n
  import prio_enc_pkg::*;
#(
  parameter  int N       = 8,
  parameter  int RR_MODE = PRIO_FIXED,
  localparam int W       = clog2_safe(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any
);

  assign any = |vec;

  generate
    if (RR_MODE == PRIO_RR) begin : g_rr
      localparam logic [W:0] NV = (W+1)'(N);
      logic [N-1:0] rot;
      logic [W:0]   k;
      logic [W:0]   sum;
      logic [W-1:0] j;

      // rot[i] = vec[(i + ptr) mod N], so an ascending scan starts at ptr.
      always_comb begin
        rot = '0;
        k   = '0;
        for (int i = 0; i < N; i++) begin
          k = (W+1)'(i) + {1'b0, ptr};
          if (k >= NV) k = k - NV;
          rot[i] = vec[k[W-1:0]];
        end
      end

      always_comb begin
        j = '0;
        for (int i = N-1; i >= 0; i--) begin
          if (rot[i]) j = W'(i);
        end
        sum = {1'b0, j} + {1'b0, ptr};
        if (sum >= NV) sum = sum - NV;
        idx = any ? sum[W-1:0] : '0;
      end
    end else begin : g_fixed
      logic unused_ptr;
      assign unused_ptr = ^ptr;

      always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
          if (vec[i]) idx = W'(i);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/prio_encoder_n.sv
// Registered N-input priority encoder with valid/ready handshake, hit count and multi/zero flags.
module prio_encoder_n
  import prio_enc_pkg::*;
#(
  parameter  int N       = 8,
  parameter  int RR_MODE = PRIO_FIXED,
  localparam int W       = clog2_safe(N),
  localparam int CW      = clog2_safe(N+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_vec,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_idx,
  output logic          out_multi,
  output logic          out_zero,
  output logic [CW-1:0] out_count
);

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_idx_q, out_idx_d;
  logic          out_multi_q, out_multi_d;
  logic          out_zero_q, out_zero_d;
  logic [CW-1:0] out_count_q, out_count_d;
  logic [W-1:0]  rr_ptr_q, rr_ptr_d;

  logic          fire_in, fire_out;
  logic [W-1:0]  ptr_in, pick_idx;
  logic          pick_any;
  logic [CW-1:0] cnt;

  assign in_ready = !out_valid_q || out_ready;
  assign fire_in  = in_valid && in_ready;
  assign fire_out = out_valid_q && out_ready;
  assign ptr_in   = (RR_MODE == PRIO_RR) ? rr_ptr_q : '0;

  prio_pick_n #(.N(N), .RR_MODE(RR_MODE)) u_pick (
    .vec (in_vec),
    .ptr (ptr_in),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) cnt = cnt + CW'(in_vec[i]);
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_multi_d = out_multi_q;
    out_zero_d  = out_zero_q;
    out_count_d = out_count_q;
    rr_ptr_d    = rr_ptr_q;
    if (fire_in) begin
      // A new accept overwrites the held result even if it is consumed this cycle.
      out_valid_d = 1'b1;
      out_idx_d   = pick_idx;
      out_count_d = cnt;
      out_multi_d = cnt > CW'(1);
      out_zero_d  = !pick_any;
      if (RR_MODE == PRIO_RR && pick_any)
        rr_ptr_d = (pick_idx == W'(N-1)) ? '0 : pick_idx + W'(1);
    end else if (fire_out) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_multi_q <= 1'b0;
      out_zero_q  <= 1'b0;
      out_count_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_multi_q <= out_multi_d;
      out_zero_q  <= out_zero_d;
      out_count_q <= out_count_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_multi = out_multi_q;
  assign out_zero  = out_zero_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_prio_encoder_n.sv
// Scoreboard bench: N=4 fixed, N=8 fixed and N=8 round-robin encoders driven side by side.
module tb_prio_encoder_n;
  import prio_enc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int multi;
    int zero;
    int count;
  } exp_t;

  exp_t q4[$], q8[$], qrr[$];
  exp_t e4, e8, err;
  int n_checks = 0;
  int n_fail   = 0;
  int ptr_m    = 0;

  logic       in_valid4 = 0, out_ready4 = 1, in_ready4, out_valid4, out_multi4, out_zero4;
  logic [3:0] in_vec4 = '0;
  logic [1:0] out_idx4;
  logic [2:0] out_count4;

  logic       in_valid8 = 0, out_ready8 = 1, in_ready8, out_valid8, out_multi8, out_zero8;
  logic [7:0] in_vec8 = '0;
  logic [2:0] out_idx8;
  logic [3:0] out_count8;

  logic       in_validr = 0, out_readyr = 1, in_readyr, out_validr, out_multir, out_zeror;
  logic [7:0] in_vecr = '0;
  logic [2:0] out_idxr;
  logic [3:0] out_countr;

  prio_encoder_n #(.N(4), .RR_MODE(PRIO_FIXED)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_vec(in_vec4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_idx(out_idx4),
    .out_multi(out_multi4), .out_zero(out_zero4), .out_count(out_count4));

  prio_encoder_n #(.N(8), .RR_MODE(PRIO_FIXED)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .in_vec(in_vec8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_idx(out_idx8),
    .out_multi(out_multi8), .out_zero(out_zero8), .out_count(out_count8));

  prio_encoder_n #(.N(8), .RR_MODE(PRIO_RR)) u_rr (
    .clk(clk), .rst(rst), .in_valid(in_validr), .in_ready(in_readyr), .in_vec(in_vecr),
    .out_valid(out_validr), .out_ready(out_readyr), .out_idx(out_idxr),
    .out_multi(out_multir), .out_zero(out_zeror), .out_count(out_countr));

  always @(posedge clk) if (in_validr) assert (!$isunknown(in_vecr));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input int idx, input logic [7:0] v);
    exp_t e;
    e.idx   = idx;
    e.count = $countones(v);
    e.zero  = (v == 8'h00) ? 1 : 0;
    e.multi = (e.count > 1) ? 1 : 0;
    return e;
  endfunction

  // Independent round-robin reference: walk upward from p with wrap.
  function automatic int rr_model(input logic [7:0] v, input int p);
    for (int k = 0; k < 8; k++) begin
      if (v[(p + k) % 8]) return (p + k) % 8;
    end
    return 0;
  endfunction

  // Monitors: one pop-and-compare per output transfer.
  always @(negedge clk) if (!rst && out_valid4 && out_ready4) begin
    n_checks++;
    if (q4.size() == 0) begin
      n_fail++; $display("FAIL d4 unexpected output idx=%0d", out_idx4);
    end else begin
      e4 = q4.pop_front();
      chk("d4 idx", 32'(out_idx4), e4.idx);
      chk("d4 multi", 32'(out_multi4), e4.multi);
      chk("d4 zero", 32'(out_zero4), e4.zero);
      chk("d4 count", 32'(out_count4), e4.count);
    end
  end

  always @(negedge clk) if (!rst && out_valid8 && out_ready8) begin
    n_checks++;
    if (q8.size() == 0) begin
      n_fail++; $display("FAIL d8 unexpected output idx=%0d", out_idx8);
    end else begin
      e8 = q8.pop_front();
      chk("d8 idx", 32'(out_idx8), e8.idx);
      chk("d8 multi", 32'(out_multi8), e8.multi);
      chk("d8 zero", 32'(out_zero8), e8.zero);
      chk("d8 count", 32'(out_count8), e8.count);
    end
  end

  always @(negedge clk) if (!rst && out_validr && out_readyr) begin
    n_checks++;
    if (qrr.size() == 0) begin
      n_fail++; $display("FAIL rr unexpected output idx=%0d", out_idxr);
    end else begin
      err = qrr.pop_front();
      chk("rr idx", 32'(out_idxr), err.idx);
      chk("rr multi", 32'(out_multir), err.multi);
      chk("rr zero", 32'(out_zeror), err.zero);
      chk("rr count", 32'(out_countr), err.count);
    end
  end

  // Drivers: present a vector, push its expectation on the accepting edge.
  task automatic send4(input logic [3:0] v, input int idx);
    int w = 0;
    in_valid4 = 1'b1; in_vec4 = v;
    @(negedge clk);
    while (!in_ready4 && w < 50) begin w++; @(negedge clk); end
    if (!in_ready4) begin n_checks++; n_fail++; $display("FAIL d4 accept timeout"); end
    else q4.push_back(mk(idx, {4'b0, v}));
    @(posedge clk); #1;
    in_valid4 = 1'b0;
  endtask

  task automatic send8(input logic [7:0] v, input int idx);
    int w = 0;
    in_valid8 = 1'b1; in_vec8 = v;
    @(negedge clk);
    while (!in_ready8 && w < 50) begin w++; @(negedge clk); end
    if (!in_ready8) begin n_checks++; n_fail++; $display("FAIL d8 accept timeout"); end
    else q8.push_back(mk(idx, v));
    @(posedge clk); #1;
    in_valid8 = 1'b0;
  endtask

  task automatic sendr(input logic [7:0] v, input int idx, output int w);
    w = 0;
    in_validr = 1'b1; in_vecr = v;
    @(negedge clk);
    while (!in_readyr && w < 50) begin w++; @(negedge clk); end
    if (!in_readyr) begin n_checks++; n_fail++; $display("FAIL rr accept timeout"); end
    else qrr.push_back(mk(idx, v));
    @(posedge clk); #1;
    in_validr = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((q4.size() + q8.size() + qrr.size()) != 0 && t < 20) begin
      @(negedge clk); t++;
    end
    n_checks++;
    if ((q4.size() + q8.size() + qrr.size()) != 0) begin
      n_fail++;
      $display("FAIL drain: pending %0d/%0d/%0d expected 0", q4.size(), q8.size(), qrr.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int w, idx;
    logic [7:0] v;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst d4 valid", 32'(out_valid4), 0);
    chk("rst d4 idx", 32'(out_idx4), 0);
    chk("rst d8 valid", 32'(out_valid8), 0);
    chk("rst d8 count", 32'(out_count8), 0);
    chk("rst rr valid", 32'(out_validr), 0);
    chk("rst rr zero", 32'(out_zeror), 0);
    chk("rst rr_ptr", 32'(u_rr.rr_ptr_q), 0);
    @(posedge clk); #1;

    // Legacy 4-to-2 map, back-to-back.
    send4(4'b0001, 0); send4(4'b0010, 1); send4(4'b0100, 2); send4(4'b1000, 3);
    send4(4'b0011, 1); send4(4'b1110, 3); send4(4'b0000, 0);

    // All-ones and all-zero at N=8.
    send8(8'hFF, 7); send8(8'h00, 0);

    // Round-robin over a held vector.
    sendr(8'b1000_0101, 0, w); chk("rr_ptr a", 32'(u_rr.rr_ptr_q), 1);
    sendr(8'b1000_0101, 2, w); chk("rr_ptr b", 32'(u_rr.rr_ptr_q), 3);
    sendr(8'b1000_0101, 7, w); chk("rr_ptr c", 32'(u_rr.rr_ptr_q), 0);
    sendr(8'b1000_0101, 0, w); chk("rr_ptr d", 32'(u_rr.rr_ptr_q), 1);
    ptr_m = 1;

    // Backpressure: hold 8'h10 result while 8'h02 waits.
    send8(8'h10, 4);
    out_ready8 = 1'b0; in_valid8 = 1'b1; in_vec8 = 8'h02;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp in_ready", 32'(in_ready8), 0);
      chk("bp out_valid", 32'(out_valid8), 1);
      chk("bp idx held", 32'(out_idx8), 4);
    end
    @(posedge clk); #1;
    out_ready8 = 1'b1;
    send8(8'h02, 1);

    // Full-throughput stream against the reference model.
    for (int n = 0; n < 16; n++) begin
      v = 8'($urandom_range(0, 255));
      idx = (v == 8'h00) ? 0 : rr_model(v, ptr_m);
      if (v != 8'h00) ptr_m = (idx == 7) ? 0 : idx + 1;
      sendr(v, idx, w);
      chk("thr no stall", 32'(w), 0);
    end
    chk("thr rr_ptr", 32'(u_rr.rr_ptr_q), 32'(ptr_m));
    drain();

    // Reset with a pending result and rr_ptr=5.
    out_readyr = 1'b0;
    sendr(8'h10, 4, w);
    @(negedge clk);
    chk("pre-rst valid", 32'(out_validr), 1);
    chk("pre-rst rr_ptr", 32'(u_rr.rr_ptr_q), 5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    qrr.delete();
    @(negedge clk);
    chk("post-rst valid", 32'(out_validr), 0);
    chk("post-rst idx", 32'(out_idxr), 0);
    chk("post-rst multi", 32'(out_multir), 0);
    chk("post-rst zero", 32'(out_zeror), 0);
    chk("post-rst count", 32'(out_countr), 0);
    chk("post-rst rr_ptr", 32'(u_rr.rr_ptr_q), 0);
    @(posedge clk); #1;
    out_readyr = 1'b1;
    sendr(8'b0010_0001, 0, w);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
